not16_bist: RTL and testbench
=============================

Name: not16_bist

Overview:
- Hardware self-test sequencer for the 16-bit inverter (Not16) and any bit-compatible 16-bit NOT datapath.
- Drives the 16-bit DUT input, waits a configurable settle time, samples the DUT output and checks it against the bitwise complement of the driven vector.
- Reports error count, first failure and pass/fail. It is the on-chip response-checking counterpart of the simulation vector benches, used for FPGA bring-up of the ALU datapath.

Parameters:
- SETTLE_CYCLES, 1, extra wait cycles between driving a vector and sampling; 0 allowed.
- LFSR_COUNT, 16, pseudo-random vectors after the fixed set; range 0..250.
- SEED, 16'hACE1, first LFSR vector; SEED==0 is substituted with 16'h0001.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a run; sampled only in IDLE.
- dut_in  out  16  vector driven to the DUT, registered.
- dut_out  in  16  DUT response, treated as combinational from dut_in.
- busy  out  1  high from start acceptance until the DONE cycle ends.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  run completed with zero mismatches; held until the next start.
- err_count  out  8  mismatch count, saturating at 255.
- first_err_idx  out  8  vector index of the first mismatch; 8'hFF if none.
- first_err_vec  out  16  dut_in value at the first mismatch; 0 if none.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. While rst_n is low: state=IDLE, dut_in=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=8'hFF, first_err_vec=0, idx=0, LFSR=SEED. Outputs take reset values immediately, without waiting for a clock edge.
- Vector list, N = 5 + LFSR_COUNT:
  - idx 0..4: 16'h0000, 16'hFFFF, 16'hAAAA, 16'h3CC3, 16'h1234.
  - idx 5..N-1: LFSR values, first = SEED; next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}. For SEED=ACE1 the second LFSR vector is 59C3.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE: dut_in=0, busy=0. On start=1:
  - Clear err_count, pass, first_err_* (to 0/FF/0).
  - Reload LFSR, set idx=0, load dut_in=vector[0] on the same edge, go to DRIVE.
- DRIVE: 1 cycle. Load settle counter with SETTLE_CYCLES. Go to SETTLE, or directly to CHECK if SETTLE_CYCLES==0.
- SETTLE: count down; at 0 go to CHECK. Occupies exactly SETTLE_CYCLES cycles.
- CHECK: 1 cycle. Compare dut_out against ~dut_in.
  - Mismatch: err_count += 1, saturating at 255. If no previous error in this run, capture first_err_idx=idx and first_err_vec=dut_in.
  - Then: if idx==N-1 go to DONE and set dut_in=0; else idx+=1, dut_in=vector[idx], advance LFSR as needed, go to DRIVE.
- DONE: 1 cycle, done=1. pass = (final err_count==0), including the last check. Then go to IDLE.
- Latency: per vector = SETTLE_CYCLES+2 cycles. Counting the first DRIVE cycle as cycle 1, done is high in cycle N*(SETTLE_CYCLES+2)+1.
- Boundary rules:
  - start while busy (DRIVE..DONE) is ignored; no queuing. start held high re-triggers only after returning to IDLE.
  - Reset mid-run aborts the run; no done pulse; results are lost.
  - err_count never wraps.
  - LFSR_COUNT=0 runs only the 5 fixed vectors.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> outputs immediately dut_in=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=FF, first_err_vec=0.
- Ideal inverter (dut_out=~dut_in), defaults, one start pulse:
  - dut_in sequence 0000, FFFF, AAAA, 3CC3, 1234, ACE1, 59C3, ...
  - done single pulse in cycle 64 (N=21).
  - pass=1, err_count=0, first_err_idx=FF.
- Stuck-at-0 on bit 0 (dut_out=~dut_in|16'h0001), LFSR_COUNT=2 -> mismatches at FFFF, 3CC3, ACE1, 59C3: err_count=4, first_err_idx=1, first_err_vec=FFFF, pass=0, done in cycle 22.
- Passthrough DUT (dut_out=dut_in), SETTLE_CYCLES=0, LFSR_COUNT=0 -> done in cycle 11, err_count=5, first_err_idx=0, first_err_vec=0000, pass=0.
- Control edge cases, defaults, ideal DUT:
  - start held high for the whole run -> exactly one done, then a new run begins.
  - rst_n pulsed low at cycle 10 -> immediate reset values, no done.
  - Fresh start after the reset -> full 64-cycle run, pass=1.
- Counter ceiling: dut_out=dut_in, LFSR_COUNT=250 -> err_count=255 with no wrap, first_err_idx=0, pass=0.

Source files
------------

// File: rtl/not16_bist.sv
// Built-in self-test sequencer for a 16-bit NOT datapath: drives fixed and LFSR vectors,
// waits a settle time, checks the response against the complement and reports the results.
module not16_bist #(
  parameter int          SETTLE_CYCLES = 1,
  parameter int          LFSR_COUNT    = 16,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [15:0] dut_in,
  input  logic [15:0] dut_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [7:0]  first_err_idx,
  output logic [15:0] first_err_vec
);

  localparam int          N          = 5 + LFSR_COUNT;
  localparam logic [7:0]  LAST_IDX   = 8'(N - 1);
  localparam logic [15:0] SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam int          SW         = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

  state_t        state, state_nxt;
  logic [7:0]    idx;
  logic [7:0]    next_idx;
  logic [15:0]   lfsr;
  logic [15:0]   lfsr_next;
  logic [SW-1:0] settle_cnt;
  logic          mismatch;
  logic          last_vec;
  logic [7:0]    err_next;

  function automatic logic [15:0] fixed_vec(input logic [2:0] i);
    case (i)
      3'd0:    fixed_vec = 16'h0000;
      3'd1:    fixed_vec = 16'hFFFF;
      3'd2:    fixed_vec = 16'hAAAA;
      3'd3:    fixed_vec = 16'h3CC3;
      default: fixed_vec = 16'h1234;
    endcase
  endfunction

  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign mismatch  = (dut_out != ~dut_in);
  assign last_vec  = (idx == LAST_IDX);
  assign next_idx  = idx + 8'd1;
  assign err_next  = (mismatch && err_count != 8'hFF) ? err_count + 8'd1 : err_count;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   state_nxt = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
      SETTLE:  if (settle_cnt <= SW'(1)) state_nxt = CHECK;
      CHECK:   state_nxt = last_vec ? DONE : DRIVE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // lfsr always holds the most recent LFSR vector; it only steps once idx passes 5
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_in        <= 16'h0000;
      pass          <= 1'b0;
      err_count     <= 8'h00;
      first_err_idx <= 8'hFF;
      first_err_vec <= 16'h0000;
      idx           <= 8'h00;
      lfsr          <= SEED_EFF;
      settle_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            err_count     <= 8'h00;
            pass          <= 1'b0;
            first_err_idx <= 8'hFF;
            first_err_vec <= 16'h0000;
            lfsr          <= SEED_EFF;
            idx           <= 8'h00;
            dut_in        <= fixed_vec(3'd0);
          end
        end
        DRIVE:  settle_cnt <= SETTLE_LOAD;
        SETTLE: settle_cnt <= settle_cnt - SW'(1);
        CHECK: begin
          err_count <= err_next;
          if (mismatch && first_err_idx == 8'hFF) begin
            first_err_idx <= idx;
            first_err_vec <= dut_in;
          end
          if (last_vec) begin
            dut_in <= 16'h0000;
            pass   <= (err_next == 8'h00);
          end else begin
            idx <= next_idx;
            if (next_idx < 8'd5) begin
              dut_in <= fixed_vec(next_idx[2:0]);
            end else if (next_idx == 8'd5) begin
              dut_in <= lfsr;
            end else begin
              lfsr   <= lfsr_next;
              dut_in <= lfsr_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_not16_bist.sv
// Directed bench for not16_bist: four instances with ideal, stuck-at, passthrough and
// long-run DUT models, plus start-hold and mid-run reset checks.
module tb_not16_bist;

  logic        clk;
  logic        rst_n;
  logic [3:0]  start_v;
  logic [3:0]  busy_v;
  logic [3:0]  done_v;
  logic [3:0]  pass_v;
  logic [15:0] din_v  [4];
  logic [15:0] dout_v [4];
  logic [7:0]  ec_v   [4];
  logic [7:0]  fi_v   [4];
  logic [15:0] fv_v   [4];

  int          tests;
  int          fails;
  bit          hold_start;
  logic [15:0] seq [7];
  int          dc;
  int          dp;
  logic        bz;
  int          late_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dout_v[0] = ~din_v[0];
  assign dout_v[1] = ~din_v[1] | 16'h0001;
  assign dout_v[2] = din_v[2];
  assign dout_v[3] = din_v[3];

  not16_bist u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .dut_in(din_v[0]), .dut_out(dout_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(ec_v[0]),
    .first_err_idx(fi_v[0]), .first_err_vec(fv_v[0])
  );

  not16_bist #(.LFSR_COUNT(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .dut_in(din_v[1]), .dut_out(dout_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(ec_v[1]),
    .first_err_idx(fi_v[1]), .first_err_vec(fv_v[1])
  );

  not16_bist #(.SETTLE_CYCLES(0), .LFSR_COUNT(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .dut_in(din_v[2]), .dut_out(dout_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(ec_v[2]),
    .first_err_idx(fi_v[2]), .first_err_vec(fv_v[2])
  );

  not16_bist #(.LFSR_COUNT(250)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .dut_in(din_v[3]), .dut_out(dout_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .err_count(ec_v[3]),
    .first_err_idx(fi_v[3]), .first_err_vec(fv_v[3])
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Cycle 1 is the first DRIVE cycle; stops at the cycle after done or when the budget runs out
  task automatic applyStimulus(input int inst, input int budget,
                               output int done_cycle, output int done_pulses, output logic busy_after);
    done_cycle  = -1;
    done_pulses = 0;
    busy_after  = 1'bx;
    @(negedge clk);
    start_v[inst] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_start) start_v[inst] = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (inst == 0 && cyc <= 19 && (cyc - 1) % 3 == 0) seq[(cyc - 1) / 3] = din_v[0];
      if (done_v[inst]) begin
        done_pulses++;
        if (done_cycle < 0) done_cycle = cyc;
      end
      if (done_cycle >= 0 && cyc == done_cycle + 1) begin
        busy_after = busy_v[inst];
        break;
      end
      @(posedge clk);
    end
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    hold_start = 1'b0;
    start_v    = 4'b0000;
    rst_n      = 1'b1;

    #12 rst_n = 1'b0;
    #1;
    checkOutput("rst_dut_in", din_v[0], 16'h0000);
    checkOutput("rst_busy", busy_v[0], 1'b0);
    checkOutput("rst_done", done_v[0], 1'b0);
    checkOutput("rst_pass", pass_v[0], 1'b0);
    checkOutput("rst_err_count", ec_v[0], 8'h00);
    checkOutput("rst_first_idx", fi_v[0], 8'hFF);
    checkOutput("rst_first_vec", fv_v[0], 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(0, 200, dc, dp, bz);
    checkOutput("ideal_vec0", seq[0], 16'h0000);
    checkOutput("ideal_vec1", seq[1], 16'hFFFF);
    checkOutput("ideal_vec2", seq[2], 16'hAAAA);
    checkOutput("ideal_vec3", seq[3], 16'h3CC3);
    checkOutput("ideal_vec4", seq[4], 16'h1234);
    checkOutput("ideal_vec5", seq[5], 16'hACE1);
    checkOutput("ideal_vec6", seq[6], 16'h59C3);
    checkOutput("ideal_done_cycle", dc, 64);
    checkOutput("ideal_done_pulses", dp, 1);
    checkOutput("ideal_pass", pass_v[0], 1'b1);
    checkOutput("ideal_err_count", ec_v[0], 8'h00);
    checkOutput("ideal_first_idx", fi_v[0], 8'hFF);
    checkOutput("ideal_first_vec", fv_v[0], 16'h0000);
    checkOutput("ideal_dut_in_idle", din_v[0], 16'h0000);

    hold_start = 1'b1;
    applyStimulus(0, 200, dc, dp, bz);
    checkOutput("hold_done_cycle", dc, 64);
    checkOutput("hold_done_pulses", dp, 1);
    checkOutput("hold_idle_busy", bz, 1'b0);
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    hold_start = 1'b0;
    @(negedge clk);
    checkOutput("hold_retrigger_busy", busy_v[0], 1'b1);

    repeat (9) @(posedge clk);
    #1;
    checkOutput("midrun_dut_in", din_v[0], 16'h3CC3);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_dut_in", din_v[0], 16'h0000);
    checkOutput("abort_busy", busy_v[0], 1'b0);
    checkOutput("abort_done", done_v[0], 1'b0);
    checkOutput("abort_pass", pass_v[0], 1'b0);
    checkOutput("abort_first_idx", fi_v[0], 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    late_done = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done_v[0]) late_done++;
    end
    checkOutput("abort_no_done", late_done, 0);

    applyStimulus(0, 200, dc, dp, bz);
    checkOutput("fresh_done_cycle", dc, 64);
    checkOutput("fresh_pass", pass_v[0], 1'b1);
    checkOutput("fresh_err_count", ec_v[0], 8'h00);

    applyStimulus(1, 200, dc, dp, bz);
    checkOutput("stuck_done_cycle", dc, 22);
    checkOutput("stuck_done_pulses", dp, 1);
    checkOutput("stuck_err_count", ec_v[1], 8'd4);
    checkOutput("stuck_first_idx", fi_v[1], 8'd1);
    checkOutput("stuck_first_vec", fv_v[1], 16'hFFFF);
    checkOutput("stuck_pass", pass_v[1], 1'b0);

    applyStimulus(2, 200, dc, dp, bz);
    checkOutput("pass_thru_done_cycle", dc, 11);
    checkOutput("pass_thru_err_count", ec_v[2], 8'd5);
    checkOutput("pass_thru_first_idx", fi_v[2], 8'd0);
    checkOutput("pass_thru_first_vec", fv_v[2], 16'h0000);
    checkOutput("pass_thru_pass", pass_v[2], 1'b0);

    applyStimulus(3, 1000, dc, dp, bz);
    checkOutput("ceiling_done_cycle", dc, 766);
    checkOutput("ceiling_err_count", ec_v[3], 8'hFF);
    checkOutput("ceiling_first_idx", fi_v[3], 8'd0);
    checkOutput("ceiling_pass", pass_v[3], 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
